// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, column scan state encoding and
// small pattern helpers.
// No ports; imported by the synchronizer, the interface users and the scanner top.
package keypad_pkg;

  localparam int N_ROWS = 3;
  localparam int N_COLS = 3;
  localparam int N_KEYS = N_ROWS * N_COLS;

  // One state per driven column; encoding value equals the column index.
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_state_e;

  // Active-low column drive for a scan state; the unused encoding falls back
  // to column 0 so exactly one column is always driven.
  function automatic logic [N_COLS-1:0] col_drive(col_state_e st);
    case (st)
      COL1:    col_drive = 3'b101;
      COL2:    col_drive = 3'b011;
      default: col_drive = 3'b110;
    endcase
  endfunction

  // Number of keys pressed in a 9-bit key pattern.
  function automatic logic [3:0] key_count(logic [N_KEYS-1:0] pat);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      n = n + {3'b000, pat[i]};
    end
    key_count = n;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the debounced key outputs toward the encoder.
// Ports: row_n (keypad -> scanner), col_n, e1..e9, multi, key_valid (scanner -> outside).
// master = scanner side, slave = keypad/encoder side.
interface keypad_scanner_if;

  logic [2:0] row_n;
  logic [2:0] col_n;
  logic       e1, e2, e3, e4, e5, e6, e7, e8, e9;
  logic       multi;
  logic       key_valid;

  modport master (
    input  row_n,
    output col_n,
    output e1, e2, e3, e4, e5, e6, e7, e8, e9,
    output multi,
    output key_valid
  );

  modport slave (
    output row_n,
    input  col_n,
    input  e1, e2, e3, e4, e5, e6, e7, e8, e9,
    input  multi,
    input  key_valid
  );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for one asynchronous, pulled-up keypad row line.
// Ports: clk, rst_n, d (async input), q (synchronized output).
// Resets to 1 so an idle (pulled-up) line reads as "not pressed".
module keypad_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 keypad scanner: rotates the column drive, snapshots the rows once per
// column, debounces whole frames and presents a one-hot key plus multi-key flag.
// Ports: clk, rst_n, kp (keypad_scanner_if.master: row_n in; col_n, e1..e9, multi, key_valid out).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int SW = $clog2(DEBOUNCE_FRAMES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES);

  // Row synchronizers
  logic [N_ROWS-1:0] row_sync;

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row_sync
    keypad_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (kp.row_n[r]),
      .q     (row_sync[r])
    );
  end

  // Column scan FSM
  col_state_e      state_q, state_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            last_dwell;
  logic            frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COL0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q + 1'b1;
    last_dwell = (dwell_q == DWELL_LAST);
    frame_end  = last_dwell && (state_q == COL2);
    if (last_dwell) begin
      dwell_d = '0;
      case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        default: state_d = COL0;
      endcase
    end
  end

  assign kp.col_n = col_drive(state_q);

  // Frame capture. The rows are taken only on the last dwell cycle so the
  // freshly driven column has had SCAN_DIV-1 cycles (including the two
  // synchronizer stages) to settle. 'frame' merges the current column's rows
  // combinationally so frame end compares a complete snapshot.
  logic [N_KEYS-1:0] snap_q;
  logic [N_KEYS-1:0] frame;

  always_comb begin
    frame = snap_q;
    if (last_dwell) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (state_q == col_state_e'(c)) begin
          for (int r = 0; r < N_ROWS; r++) begin
            frame[c + N_COLS*r] = ~row_sync[r];
          end
        end
      end
    end
  end

  // Frame debounce
  logic [N_KEYS-1:0] prev_q;
  logic [SW-1:0]     stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
    end else begin
      snap_q <= frame;
      if (frame_end) begin
        prev_q <= frame;
        if (frame == prev_q) begin
          if (stable_q != STABLE_MAX) stable_q <= stable_q + 1'b1;
        end else begin
          stable_q <= '0;
        end
      end
    end
  end

  // Accepted pattern and registered outputs. While the counter sits at its
  // ceiling prev_q is, by construction, the stable pattern; reloading it each
  // cycle is harmless because key_valid only fires on an actual change.
  logic [N_KEYS-1:0] acc_q, acc_d;
  logic [N_KEYS-1:0] e_q;
  logic              multi_q;
  logic              key_valid_q;
  logic [3:0]        acc_cnt;
  logic              single;

  always_comb begin
    acc_d   = (stable_q == STABLE_MAX) ? prev_q : acc_q;
    acc_cnt = key_count(acc_d);
    single  = (acc_cnt == 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      e_q         <= '0;
      multi_q     <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      e_q         <= single ? acc_d : '0;
      multi_q     <= (acc_cnt >= 4'd2);
      key_valid_q <= single && (acc_d != acc_q);
    end
  end

  assign kp.e1        = e_q[0];
  assign kp.e2        = e_q[1];
  assign kp.e3        = e_q[2];
  assign kp.e4        = e_q[3];
  assign kp.e5        = e_q[4];
  assign kp.e6        = e_q[5];
  assign kp.e7        = e_q[6];
  assign kp.e8        = e_q[7];
  assign kp.e9        = e_q[8];
  assign kp.multi     = multi_q;
  assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2.
// A behavioural keypad pulls a row low when its column is driven and a key is held.
// All comparisons go through chk(); one summary line at the end.
module tb_keypad_scanner;

  localparam int FRAME = 12;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] keys  = '0;   // bit n-1 = key n held

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // Keypad: row r low if any held key in that row sits on the driven column.
  assign kif.row_n[0] = ~|(keys[2:0] & ~kif.col_n);
  assign kif.row_n[1] = ~|(keys[5:3] & ~kif.col_n);
  assign kif.row_n[2] = ~|(keys[8:6] & ~kif.col_n);

  logic [8:0] e_vec;
  assign e_vec = {kif.e9, kif.e8, kif.e7, kif.e6, kif.e5,
                  kif.e4, kif.e3, kif.e2, kif.e1};

  int kv_cnt = 0;
  always @(posedge clk) begin
    if (kif.key_valid) kv_cnt <= kv_cnt + 1;
  end

  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] e_or;
  logic       multi_or;
  int         kv_base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and accumulating outputs.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      e_or     = e_or | e_vec;
      multi_or = multi_or | kif.multi;
    end
  endtask

  // Return just after COL0 becomes active (col_n 011 -> 110).
  task automatic frame_start(input string tag);
    logic [2:0] prev;
    logic       ok;
    ok   = 1'b0;
    prev = kif.col_n;
    for (int i = 0; i < 2*FRAME && !ok; i++) begin
      tick(1);
      if (prev == 3'b011 && kif.col_n == 3'b110) ok = 1'b1;
      prev = kif.col_n;
    end
    if (!ok) chk({tag, "_frame_sync"}, 32'(ok), 32'd1);
  endtask

  task automatic clear_acc();
    e_or     = '0;
    multi_or = 1'b0;
    kv_base  = kv_cnt;
  endtask

  logic [2:0] exp_col [3];
  logic       found;
  int         lat;

  initial begin
    exp_col[0] = 3'b110;
    exp_col[1] = 3'b101;
    exp_col[2] = 3'b011;
    e_or     = '0;
    multi_or = 1'b0;
    kv_base  = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_col_n",     32'(kif.col_n),     32'h6);
    chk("rst_e",         32'(e_vec),         32'h0);
    chk("rst_multi",     32'(kif.multi),     32'h0);
    chk("rst_key_valid", 32'(kif.key_valid), 32'h0);

    // Column rotation, 4 cycles per column, starting at COL0
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("col_seq_%0d", i), 32'(kif.col_n), 32'(exp_col[i/4]));
    end

    // Idle: nothing ever asserted
    clear_acc();
    tick(10*FRAME);
    chk("idle_e",     32'(e_or),             32'h0);
    chk("idle_multi", 32'(multi_or),         32'h0);
    chk("idle_kv",    32'(kv_cnt - kv_base), 32'd0);

    // Key 1: accepted within 3 frames + 2 cycles of a frame-aligned press
    frame_start("k1");
    clear_acc();
    keys  = 9'h001;
    found = 1'b0;
    lat   = 0;
    while (!found && lat < 6*FRAME) begin
      tick(1);
      lat++;
      if (e_vec != 9'h0) found = 1'b1;
    end
    chk("k1_found",      32'(found),            32'd1);
    chk("k1_latency_ok", 32'(lat <= 3*FRAME+2), 32'd1);
    chk("k1_e",          32'(e_vec),            32'h001);
    tick(4*FRAME);
    chk("k1_hold_e",     32'(e_vec),            32'h001);
    chk("k1_multi",      32'(multi_or),         32'h0);
    chk("k1_kv_once",    32'(kv_cnt - kv_base), 32'd1);

    // Release key 1: e-lines clear, no pulse
    clear_acc();
    keys = 9'h000;
    tick(5*FRAME);
    chk("k1_rel_e",  32'(e_vec),            32'h0);
    chk("k1_rel_kv", 32'(kv_cnt - kv_base), 32'd0);

    // Key 5 bouncing every frame: never accepted
    clear_acc();
    for (int f = 0; f < 6; f++) begin
      frame_start("k5");
      keys = f[0] ? 9'h000 : 9'h010;
    end
    frame_start("k5_rel");
    keys = 9'h000;
    tick(5*FRAME);
    chk("bounce_e",  32'(e_or),             32'h0);
    chk("bounce_kv", 32'(kv_cnt - kv_base), 32'd0);

    // Keys 3 and 7 together: multi only
    frame_start("k37");
    clear_acc();
    keys = 9'h044;
    tick(5*FRAME);
    chk("k37_multi", 32'(kif.multi),        32'h1);
    chk("k37_e",     32'(e_or),             32'h0);
    chk("k37_kv",    32'(kv_cnt - kv_base), 32'd0);

    // Release key 7: key 3 remains and is reported
    frame_start("k3");
    clear_acc();
    keys = 9'h004;
    tick(5*FRAME);
    chk("k3_e",     32'(e_vec),            32'h004);
    chk("k3_multi", 32'(kif.multi),        32'h0);
    chk("k3_kv",    32'(kv_cnt - kv_base), 32'd1);

    // Release key 3
    clear_acc();
    keys = 9'h000;
    tick(5*FRAME);
    chk("k3_rel_e",  32'(e_vec),            32'h0);
    chk("k3_rel_kv", 32'(kv_cnt - kv_base), 32'd0);

    // Key 9 accepted, then reset mid-COL1 while still held
    frame_start("k9");
    clear_acc();
    keys = 9'h100;
    tick(5*FRAME);
    chk("k9_e",  32'(e_vec),            32'h100);
    chk("k9_kv", 32'(kv_cnt - kv_base), 32'd1);

    found = 1'b0;
    for (int i = 0; i < 2*FRAME && !found; i++) begin
      tick(1);
      if (kif.col_n == 3'b101) found = 1'b1;
    end
    chk("k9_col1_seen", 32'(found), 32'd1);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("k9_rst_e",     32'(e_vec),         32'h0);
    chk("k9_rst_multi", 32'(kif.multi),     32'h0);
    chk("k9_rst_kv",    32'(kif.key_valid), 32'h0);
    chk("k9_rst_col_n", 32'(kif.col_n),     32'h6);
    tick(3);
    clear_acc();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6*FRAME && !found; i++) begin
      tick(1);
      if (e_vec == 9'h100) found = 1'b1;
    end
    chk("k9_reaccept",    32'(found),            32'd1);
    tick(2);
    chk("k9_reaccept_kv", 32'(kv_cnt - kv_base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
